// File: rtl/endian_swap_pkg.sv
// endian_swap_pkg: mode encoding and FSM state types shared by the endian swap stream.
package endian_swap_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_BYTE   = 2'd1,
    MODE_BITREV = 2'd2,
    MODE_HALF   = 2'd3
  } mode_t;
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;
endpackage

// File: rtl/endian_swap_lanes.sv
// endian_swap_lanes: combinational pass / byte swap / bit reverse / halfword swap of one beat.
module endian_swap_lanes import endian_swap_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] byte_sw, bit_rev, half_sw;
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_byte
    assign byte_sw[8*i +: 8] = d[DATA_W-8-8*i +: 8];
  end
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign bit_rev[i] = d[DATA_W-1-i];
  end
  for (genvar i = 0; i < DATA_W / 16; i++) begin : g_half
    assign half_sw[16*i +: 16] = d[DATA_W-16-16*i +: 16];
  end
  always_comb q = mode == MODE_BYTE   ? byte_sw :
                  mode == MODE_BITREV ? bit_rev :
                  mode == MODE_HALF   ? half_sw : d;
endmodule

// File: rtl/endian_swap_stream.sv
// endian_swap_stream: packet-aligned runtime beat reordering behind a registered 2-entry skid buffer.
module endian_swap_stream import endian_swap_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_wr,
  output logic [1:0]        cur_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  pkt_cnt
);
  state_t            state_q, state_d;
  logic [1:0]        pend_q, pend_d, cur_q, cur_d, beat_mode;
  logic              ready_q, ready_d, accept, out_free;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d, xd;
  logic [CNT_W-1:0]  beat_q, beat_d, pkt_q, pkt_d;
  assign accept    = s_valid & ready_q;
  // a cfg_wr landing on the first beat of a packet bypasses the pending register
  assign beat_mode = state_q == IDLE ? (cfg_wr ? cfg_mode : pend_q) : cur_q;
  endian_swap_lanes #(.DATA_W(DATA_W)) u_lanes (.mode(beat_mode), .d(s_data), .q(xd));
  always_comb begin
    pend_d       = cfg_wr ? cfg_mode : pend_q;
    cur_d        = accept && state_q == IDLE ? beat_mode : cur_q;
    state_d      = accept ? (s_last ? IDLE : IN_PKT) : state_q;
    beat_d       = !accept ? beat_q : s_last ? '0 : (&beat_q ? beat_q : beat_q + 1'b1);
    pkt_d        = accept && s_last ? pkt_q + 1'b1 : pkt_q;
    out_free     = !out_valid_q | m_ready;
    // ready is only high when skid is empty, so skid never refills while it drains
    out_valid_d  = out_free ? (skid_valid_q | accept) : 1'b1;
    out_data_d   = !out_free ? out_data_q : skid_valid_q ? skid_data_q : accept ? xd : out_data_q;
    out_last_d   = !out_free ? out_last_q : skid_valid_q ? skid_last_q : accept ? s_last : out_last_q;
    skid_valid_d = out_free ? 1'b0 : (skid_valid_q | accept);
    skid_data_d  = !out_free && accept ? xd : skid_data_q;
    skid_last_d  = !out_free && accept ? s_last : skid_last_q;
    ready_d      = !skid_valid_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= MODE_PASS;
      cur_q        <= MODE_PASS;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      beat_q       <= '0;
      pkt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cur_q        <= cur_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      beat_q       <= beat_d;
      pkt_q        <= pkt_d;
    end
  end
  assign s_ready  = ready_q;
  assign m_valid  = out_valid_q;
  assign m_data   = out_data_q;
  assign m_last   = out_last_q;
  assign cur_mode = cur_q;
  assign beat_cnt = beat_q;
  assign pkt_cnt  = pkt_q;
endmodule

// File: tb/tb_endian_swap_stream.sv
// tb_endian_swap_stream: scoreboard bench for the 32-bit instance plus direct checks on a 64-bit/4-bit-counter instance.
module tb_endian_swap_stream;
  logic        clk = 0, rst;
  logic [1:0]  cfg_mode, cur_mode;
  logic        cfg_wr, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] s_data, m_data;
  logic [15:0] beat_cnt, pkt_cnt;
  logic [1:0]  w_mode, w_cur;
  logic        w_wr, w_valid, w_ready, w_last, w_m_valid, w_m_ready, w_m_last;
  logic [63:0] w_data, w_m_data;
  logic [3:0]  w_beat, w_pkt;
  int          errors = 0, checks = 0, exp_pkt = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  endian_swap_stream #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_wr(cfg_wr), .cur_mode(cur_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt));

  endian_swap_stream #(.DATA_W(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .cfg_mode(w_mode), .cfg_wr(w_wr), .cur_mode(w_cur),
    .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data), .s_last(w_last),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .m_last(w_m_last),
    .beat_cnt(w_beat), .pkt_cnt(w_pkt));

  task automatic send(input logic [31:0] d, input logic l, input logic [31:0] e);
    int t;
    t = 0;
    s_data = d; s_last = l; s_valid = 1;
    @(negedge clk);
    while (!s_ready && t < 50) begin t++; @(negedge clk); end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout data=%h s_ready=%b required 1", d, s_ready);
    end else begin
      q.push_back({l, e});
      if (l) exp_pkt++;
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    cfg_mode = m; cfg_wr = 1;
    @(posedge clk); #1;
    cfg_wr = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin t++; @(posedge clk); end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", q.size());
    end
    checks++;
    if (pkt_cnt !== 16'(exp_pkt)) begin
      errors++;
      $display("FAIL pkt_cnt got=%0d required %0d", pkt_cnt, exp_pkt);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({s_ready, m_valid, m_last, cur_mode, beat_cnt, pkt_cnt} !== '0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state ready=%b valid=%b data=%h last=%b mode=%0d beat=%0d pkt=%0d required all 0",
               s_ready, m_valid, m_data, m_last, cur_mode, beat_cnt, pkt_cnt);
    end
    rst = 0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b required 1", s_ready); end
  endtask

  task automatic test_byte_swap();
    set_mode(2'd1);
    send(32'h11223344, 1, 32'h44332211);
    checks++;
    if (m_valid !== 1'b1 || pkt_cnt !== 16'd1 || cur_mode !== 2'd1) begin
      errors++;
      $display("FAIL latency1 valid=%b pkt=%0d mode=%0d required 1 1 1", m_valid, pkt_cnt, cur_mode);
    end
    drain();
  endtask

  task automatic test_modes();
    set_mode(2'd2); send(32'h00000001, 1, 32'h80000000);
    set_mode(2'd3); send(32'h11223344, 1, 32'h33441122);
    set_mode(2'd0); send(32'hDEADBEEF, 1, 32'hDEADBEEF);
    drain();
  endtask

  task automatic test_cfg_bypass();
    cfg_mode = 2'd3; cfg_wr = 1;
    send(32'h11223344, 1, 32'h33441122);
    cfg_wr = 0;
    checks++;
    if (cur_mode !== 2'd3) begin errors++; $display("FAIL cfg_bypass_mode got=%0d required 3", cur_mode); end
    set_mode(2'd1);
    set_mode(2'd2);
    send(32'h00000001, 1, 32'h80000000);
    drain();
  endtask

  task automatic test_pkt_aligned();
    set_mode(2'd1);
    send(32'h01020304, 0, 32'h04030201);
    send(32'h05060708, 0, 32'h08070605);
    checks++;
    if (beat_cnt !== 16'd2) begin errors++; $display("FAIL beat_cnt_mid got=%0d required 2", beat_cnt); end
    set_mode(2'd2);
    send(32'h090A0B0C, 0, 32'h0C0B0A09);
    send(32'h0D0E0F10, 1, 32'h100F0E0D);
    checks++;
    if (cur_mode !== 2'd1 || beat_cnt !== 16'd0) begin
      errors++;
      $display("FAIL pkt_end mode=%0d beat=%0d required 1 0", cur_mode, beat_cnt);
    end
    send(32'h00000001, 1, 32'h80000000);
    checks++;
    if (cur_mode !== 2'd2) begin errors++; $display("FAIL next_pkt_mode got=%0d required 2", cur_mode); end
    drain();
  endtask

  task automatic test_back_to_back();
    set_mode(2'd0);
    fork
      for (int i = 0; i < 8; i++) send(32'(i), i == 7, 32'(i));
      begin
        repeat (3) @(posedge clk);
        #1;
        m_ready = 0;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b required 0", s_ready); end
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid_packet();
    set_mode(2'd1);
    send(32'h11223344, 0, 32'h44332211);
    send(32'hAABBCCDD, 0, 32'hDDCCBBAA);
    rst = 1;
    q.delete();
    exp_pkt = 0;
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b0 || cur_mode !== 2'd0 || beat_cnt !== 16'd0 || pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset valid=%b mode=%0d beat=%0d pkt=%0d required 0 0 0 0", m_valid, cur_mode, beat_cnt, pkt_cnt);
    end
    rst = 0;
    send(32'hDEADBEEF, 1, 32'hDEADBEEF);
    drain();
  endtask

  task automatic test_wide_and_wrap();
    int t;
    w_mode = 2'd1; w_wr = 1; w_valid = 1; w_last = 1; w_data = 64'h0102030405060708;
    @(posedge clk); #1;
    w_wr = 0;
    checks++;
    if (w_m_valid !== 1'b1 || w_m_data !== 64'h0807060504030201 || w_m_last !== 1'b1) begin
      errors++;
      $display("FAIL wide_byte valid=%b data=%h last=%b required 1 0807060504030201 1", w_m_valid, w_m_data, w_m_last);
    end
    for (int i = 1; i < 17; i++) begin
      w_data = 64'(i);
      t = 0;
      while (!w_ready && t < 20) begin t++; @(posedge clk); #1; end
      @(posedge clk); #1;
    end
    w_valid = 0;
    checks++;
    if (w_pkt !== 4'd1) begin errors++; $display("FAIL pkt_wrap got=%0d required 1", w_pkt); end
    w_last = 0; w_valid = 1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (w_beat !== 4'd15) begin errors++; $display("FAIL beat_saturate got=%0d required 15", w_beat); end
    w_last = 1;
    @(posedge clk); #1;
    w_valid = 0;
    checks++;
    if (w_beat !== 4'd0 || w_pkt !== 4'd2) begin
      errors++;
      $display("FAIL sat_pkt_end beat=%0d pkt=%0d required 0 2", w_beat, w_pkt);
    end
  endtask

  initial begin
    rst = 1; cfg_mode = 0; cfg_wr = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    w_mode = 0; w_wr = 0; w_valid = 0; w_data = 0; w_last = 0; w_m_ready = 1;
    fork
      forever begin
        @(negedge clk);
        if (!rst && m_valid) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected data=%h last=%b required no beat", m_data, m_last);
          end else begin
            if ({m_last, m_data} !== q[0]) begin
              errors++;
              $display("FAIL out_beat data=%h last=%b required %h %b", m_data, m_last, q[0][31:0], q[0][32]);
            end
            if (m_ready) void'(q.pop_front());
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_byte_swap();
    test_modes();
    test_cfg_bypass();
    test_pkt_aligned();
    test_back_to_back();
    test_reset_mid_packet();
    test_wide_and_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/endian_swap_stream.md
Name: endian_swap_stream

Overview:
- Streaming, parametrised successor to the fixed 32-bit bit-order swapper.
- Reorders each data beat by a runtime-selected mode: pass, byte swap, full bit reverse, or halfword swap.
- Sits between a valid/ready producer (bus/DMA side) and a consumer (crypto/hash core side).
- Mode changes are packet-aligned, and the block is fully registered with a 2-entry skid buffer, so there is no combinational ready path.

Parameters:
- DATA_W, 32, beat width in bits. Must be a multiple of 16 and at least 16.
- CNT_W, 16, width of the beat and packet counters.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_mode  in  2  requested mode: 0=PASS, 1=BYTE_SWAP, 2=BIT_REV, 3=HALF_SWAP.
- cfg_wr  in  1  one-cycle strobe; latches cfg_mode into the pending register.
- cur_mode  out  2  mode applied to the packet in progress.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input ready.
- s_data  in  DATA_W  input beat.
- s_last  in  1  last beat of the packet.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  transformed beat.
- m_last  out  1  copy of s_last for that beat.
- beat_cnt  out  CNT_W  beats accepted in the current packet; reset to 0 on the accepted last beat.
- pkt_cnt  out  CNT_W  packets completed; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: s_ready=0 during rst and 1 on the first cycle after; m_valid=0; m_data=0; m_last=0; cur_mode=PASS; pending mode=PASS; beat_cnt=0; pkt_cnt=0; FSM=IDLE.
- Transfer rule: a transfer occurs when valid&ready are high on a clock edge. m_data/m_last hold stable while m_valid=1 and m_ready=0.
- Transforms, for data d:
  - PASS: out=d.
  - BYTE_SWAP: byte i goes to byte (N-1-i), N=DATA_W/8.
  - BIT_REV: bit i goes to bit (DATA_W-1-i).
  - HALF_SWAP: 16-bit unit j goes to unit (H-1-j), H=DATA_W/16. Bytes inside each halfword are unchanged.
  - Example at DATA_W=16: HALF_SWAP is identical to PASS.
- Latency: exactly 1 cycle from an accepted input to m_valid when the output is empty. Sustained throughput is 1 beat/cycle with m_ready held high.
- Skid buffer: 2 entries (output register plus skid register).
  - s_ready = !(skid entry occupied); it is registered.
  - When m_ready drops, at most one further beat is absorbed into skid.
  - Output order is strictly FIFO.
- FSM:
  - IDLE: on an accepted beat, cur_mode <= pending and that beat uses the new mode. If s_last=1 the FSM stays in IDLE; otherwise it goes to IN_PKT.
  - IN_PKT: beats use cur_mode. On an accepted beat with s_last=1 the FSM goes to IDLE and pkt_cnt increments.
- The transform is applied at acceptance using the mode in effect for that beat. Beats held in the buffer are never re-transformed.
- cfg_wr behaviour:
  - cfg_wr in any state updates pending only; it never changes the packet in progress.
  - If cfg_wr coincides with the first beat of a packet in IDLE, the new cfg_mode applies to that beat, because it bypasses pending.
  - Multiple cfg_wr pulses before the next packet: the last one wins.
- beat_cnt saturates at 2^CNT_W-1 and does not wrap. pkt_cnt wraps.
- Reset mid-packet: reset flushes both buffer entries (m_valid=0), the FSM returns to IDLE, and all counters clear. No partial beat is emitted after rst.
- An s_last beat with no preceding beats (a 1-beat packet) is legal.

Decomposition:
- Package endian_swap_pkg holds:
  - the mode encoding constants MODE_PASS/BYTE/BITREV/HALF and the 2-bit mode typedef;
  - the FSM state typedef (IDLE, IN_PKT).
- One combinational sub-module, endian_swap_lanes (DATA_W, mode, d -> q), implements the four transforms with generate loops. It is reusable elsewhere.
- The top level holds the FSM, the mode registers, the skid buffer and the counters.

Test Plan:
1. DATA_W=32, mode BYTE_SWAP, s_data=0x11223344 with s_last=1 -> m_data=0x44332211 one cycle later, m_last=1, pkt_cnt=1.
2. BIT_REV, 0x00000001 -> 0x80000000; HALF_SWAP, 0x11223344 -> 0x33441122; PASS, 0xDEADBEEF -> 0xDEADBEEF.
3. Packet of 4 beats in BYTE_SWAP; cfg_wr BIT_REV after beat 2 -> beats 3-4 still byte-swapped. The next packet's first beat 0x00000001 -> 0x80000000.
4. Backpressure: stream 8 beats 0x0..0x7 with m_ready low for 3 cycles mid-stream -> s_ready falls within 1 cycle. All 8 beats arrive in order with no loss or duplication, and m_data is stable while stalled.
5. rst asserted after 2 beats of a 5-beat packet -> next cycle m_valid=0, cur_mode=PASS, beat_cnt=0, pkt_cnt=0. The following packet passes data unchanged.
6. DATA_W=64, BYTE_SWAP, 0x0102030405060708 -> 0x0807060504030201; CNT_W=4, send 17 one-beat packets -> pkt_cnt=1.
